// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-evaluation window scanner.
// Latency: none (package only).
// Backpressure: none (package only).
package pe_pkg;

  localparam int unsigned PE_SCREEN_W = 240;
  localparam int unsigned PE_SCREEN_H = 160;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } pe_scan_state_t;

  // Packed so {winNh, winNv} maps directly onto {x1, x2, y1, y2}.
  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] y1;
    logic [7:0] y2;
  } pe_win_rect_t;

endpackage

// File: rtl/pe_win_range_check.sv
// Clamp a window rectangle's exclusive edges and test a point against it.
// Latency: purely combinational.
// Backpressure: none.
module pe_win_range_check
  import pe_pkg::*;
#(
  parameter int unsigned SCREEN_W = PE_SCREEN_W,
  parameter int unsigned SCREEN_H = PE_SCREEN_H
) (
  input  pe_win_rect_t rect,
  input  logic [7:0]   x,
  input  logic [7:0]   y,
  output logic         hin,
  output logic         vin
);

  localparam logic [7:0] W8 = 8'(SCREEN_W);
  localparam logic [7:0] H8 = 8'(SCREEN_H);

  logic [7:0] x2_eff;
  logic [7:0] y2_eff;

  // An off-screen or inverted right/bottom edge extends the window to the screen edge.
  always_comb begin
    x2_eff = rect.x2;
    y2_eff = rect.y2;
    if ((rect.x2 > W8) || (rect.x1 > rect.x2)) x2_eff = W8;
    if ((rect.y2 > H8) || (rect.y1 > rect.y2)) y2_eff = H8;
    hin = (x >= rect.x1) && (x < x2_eff);
    vin = (y >= rect.y1) && (y < y2_eff);
  end

endmodule

// File: rtl/pe_window_scanner.sv
// Per-pixel WIN0/WIN1 membership sequencer; optional macro PE_WIN_SHADOW_EN latches window regs per line.
// Latency: flags for a pixel appear exactly 1 cycle after its pixel_en.
// Backpressure: none; pixel_en is ignored outside a visible line, line_start always wins.
module pe_window_scanner
  import pe_pkg::*;
#(
  parameter int unsigned SCREEN_W = PE_SCREEN_W,
  parameter int unsigned SCREEN_H = PE_SCREEN_H
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dispcnt,
  input  logic [15:0] win0h,
  input  logic [15:0] win1h,
  input  logic [15:0] win0v,
  input  logic [15:0] win1v,
  input  logic        line_start,
  input  logic [7:0]  vcount,
  input  logic        pixel_en,
  output logic        win0,
  output logic        win1,
  output logic [7:0]  pixel_x,
  output logic        pixel_valid,
  output logic        line_done
);

  localparam logic [7:0] W8 = 8'(SCREEN_W);
  localparam logic [7:0] H8 = 8'(SCREEN_H);

  pe_scan_state_t state_q, state_d;
  logic [7:0] x_q, x_d;
  logic       win0_q, win0_d, win1_q, win1_d;
  logic [7:0] pixel_x_q, pixel_x_d;
  logic       pixel_valid_q, pixel_valid_d;
  logic       line_done_q, line_done_d;

  logic [15:0] h0_src, h1_src;
  logic        en0_src, en1_src;
  logic        vin0_use, vin1_use;
  logic [7:0]  y_chk;
  logic        hin0, hin1, vin0_chk, vin1_chk;

  // Only the two window-enable bits of DISPCNT matter here.
  logic unused_dispcnt;
  assign unused_dispcnt = ^{dispcnt[15], dispcnt[12:0]};

`ifdef PE_WIN_SHADOW_EN
  logic [15:0] win0h_q, win0h_d, win1h_q, win1h_d;
  logic        en0_q, en0_d, en1_q, en1_d;
  logic        vin0_q, vin0_d, vin1_q, vin1_d;

  // Horizontal edges and enables come from the per-line copies; vertical is judged once at line_start.
  assign h0_src   = win0h_q;
  assign h1_src   = win1h_q;
  assign en0_src  = en0_q;
  assign en1_src  = en1_q;
  assign y_chk    = vcount;
  assign vin0_use = vin0_q;
  assign vin1_use = vin1_q;
`else
  logic [7:0] vline_q, vline_d;

  // Everything live except the line number, which is only valid during line_start.
  assign h0_src   = win0h;
  assign h1_src   = win1h;
  assign en0_src  = dispcnt[13];
  assign en1_src  = dispcnt[14];
  assign y_chk    = vline_q;
  assign vin0_use = vin0_chk;
  assign vin1_use = vin1_chk;
`endif

  pe_win_range_check #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_chk0 (
    .rect ({h0_src, win0v}),
    .x    (x_q),
    .y    (y_chk),
    .hin  (hin0),
    .vin  (vin0_chk)
  );

  pe_win_range_check #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_chk1 (
    .rect ({h1_src, win1v}),
    .x    (x_q),
    .y    (y_chk),
    .hin  (hin1),
    .vin  (vin1_chk)
  );

  // Next-state: line_start (re)arms a line, ACTIVE emits one flag set per pixel_en, DONE pulses line_done.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    win0_d        = win0_q;
    win1_d        = win1_q;
    pixel_x_d     = pixel_x_q;
    pixel_valid_d = 1'b0;
    line_done_d   = 1'b0;
`ifdef PE_WIN_SHADOW_EN
    win0h_d = win0h_q;
    win1h_d = win1h_q;
    en0_d   = en0_q;
    en1_d   = en1_q;
    vin0_d  = vin0_q;
    vin1_d  = vin1_q;
`else
    vline_d = vline_q;
`endif
    if (line_start) begin
      x_d = 8'd0;
      if (vcount < H8) begin
        state_d = ACTIVE;
`ifdef PE_WIN_SHADOW_EN
        win0h_d = win0h;
        win1h_d = win1h;
        en0_d   = dispcnt[13];
        en1_d   = dispcnt[14];
        vin0_d  = vin0_chk;
        vin1_d  = vin1_chk;
`else
        vline_d = vcount;
`endif
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        ACTIVE: begin
          if (pixel_en) begin
            win0_d        = en0_src & vin0_use & hin0;
            win1_d        = en1_src & vin1_use & hin1;
            pixel_x_d     = x_q;
            pixel_valid_d = 1'b1;
            if (x_q == W8 - 8'd1) state_d = DONE;
            else                  x_d     = x_q + 8'd1;
          end
        end
        DONE: begin
          line_done_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; reset returns everything to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= 8'd0;
      win0_q        <= 1'b0;
      win1_q        <= 1'b0;
      pixel_x_q     <= 8'd0;
      pixel_valid_q <= 1'b0;
      line_done_q   <= 1'b0;
`ifdef PE_WIN_SHADOW_EN
      win0h_q <= 16'd0;
      win1h_q <= 16'd0;
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      vin0_q  <= 1'b0;
      vin1_q  <= 1'b0;
`else
      vline_q <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      win0_q        <= win0_d;
      win1_q        <= win1_d;
      pixel_x_q     <= pixel_x_d;
      pixel_valid_q <= pixel_valid_d;
      line_done_q   <= line_done_d;
`ifdef PE_WIN_SHADOW_EN
      win0h_q <= win0h_d;
      win1h_q <= win1h_d;
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      vin0_q  <= vin0_d;
      vin1_q  <= vin1_d;
`else
      vline_q <= vline_d;
`endif
    end
  end

  assign win0        = win0_q;
  assign win1        = win1_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_valid = pixel_valid_q;
  assign line_done   = line_done_q;

endmodule

// File: tb/tb_pe_window_scanner.sv
// Self-checking bench for pe_window_scanner: directed scanlines plus randomized lines against a behavioural model.
// Latency: model predicts outputs one cycle after each sampled input set.
// Backpressure: n/a.
module tb_pe_window_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dispcnt, win0h, win1h, win0v, win1v;
  logic        line_start;
  logic [7:0]  vcount;
  logic        pixel_en;
  logic        win0, win1, pixel_valid, line_done;
  logic [7:0]  pixel_x;

  pe_window_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .dispcnt     (dispcnt),
    .win0h       (win0h),
    .win1h       (win1h),
    .win0v       (win0v),
    .win1v       (win1v),
    .line_start  (line_start),
    .vcount      (vcount),
    .pixel_en    (pixel_en),
    .win0        (win0),
    .win1        (win1),
    .pixel_x     (pixel_x),
    .pixel_valid (pixel_valid),
    .line_done   (line_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Is p inside [lo, hi) once an off-screen or inverted hi is replaced by lim?
  function automatic bit in_span(input int lo, input int hi, input int lim, input int p);
    int top;
    top = ((hi > lim) || (lo > hi)) ? lim : hi;
    return (p >= lo) && (p < top);
  endfunction

  bit          armed = 0;
  bit          m_in_line, m_done_due;
  int          m_x, m_line;
  bit          m_vin0, m_vin1, s_en0, s_en1;
  logic [15:0] s_h0, s_h1;
  logic        e_w0, e_w1, e_pv, e_ld;
  logic [7:0]  e_px;
  logic [15:0] u_h0, u_h1;
  bit          u_en0, u_en1, u_v0, u_v1;

  always @(posedge clock) begin
    if (reset) begin
      armed = 1; m_in_line = 0; m_done_due = 0; m_x = 0; m_line = 0;
      m_vin0 = 0; m_vin1 = 0; s_en0 = 0; s_en1 = 0; s_h0 = 0; s_h1 = 0;
      e_w0 = 0; e_w1 = 0; e_pv = 0; e_ld = 0; e_px = 0;
    end else begin
      e_pv = 0;
      e_ld = 0;
      if (line_start) begin
        m_done_due = 0;
        if (vcount < 160) begin
          m_in_line = 1; m_x = 0; m_line = vcount;
          s_h0 = win0h; s_h1 = win1h; s_en0 = dispcnt[13]; s_en1 = dispcnt[14];
          m_vin0 = in_span(win0v[15:8], win0v[7:0], 160, vcount);
          m_vin1 = in_span(win1v[15:8], win1v[7:0], 160, vcount);
        end else begin
          m_in_line = 0;
        end
      end else if (m_done_due) begin
        e_ld = 1;
        m_done_due = 0;
      end else if (m_in_line && pixel_en) begin
`ifdef PE_WIN_SHADOW_EN
        u_h0 = s_h0; u_h1 = s_h1; u_en0 = s_en0; u_en1 = s_en1; u_v0 = m_vin0; u_v1 = m_vin1;
`else
        u_h0 = win0h; u_h1 = win1h; u_en0 = dispcnt[13]; u_en1 = dispcnt[14];
        u_v0 = in_span(win0v[15:8], win0v[7:0], 160, m_line);
        u_v1 = in_span(win1v[15:8], win1v[7:0], 160, m_line);
`endif
        e_w0 = u_en0 && u_v0 && in_span(u_h0[15:8], u_h0[7:0], 240, m_x);
        e_w1 = u_en1 && u_v1 && in_span(u_h1[15:8], u_h1[7:0], 240, m_x);
        e_px = 8'(m_x);
        e_pv = 1;
        if (m_x == 239) begin
          m_in_line = 0;
          m_done_due = 1;
        end else begin
          m_x++;
        end
      end
    end
  end

  // ---------------- compare process + line statistics ----------------
  int n_w0, n_w1, n_pv, n_ld, f_w0, l_w0, f_w1, last_px;

  task automatic clr_stats();
    n_w0 = 0; n_w1 = 0; n_pv = 0; n_ld = 0; f_w0 = -1; l_w0 = -1; f_w1 = -1; last_px = -1;
  endtask

  always @(negedge clock) begin
    if (armed) begin
      chk("pixel_valid", pixel_valid, e_pv);
      chk("line_done", line_done, e_ld);
      chk("win0", win0, e_w0);
      chk("win1", win1, e_w1);
      chk("pixel_x", pixel_x, e_px);
      if (pixel_valid === 1'b1) begin
        n_pv++;
        last_px = pixel_x;
        if (win0 === 1'b1) begin
          n_w0++;
          if (f_w0 < 0) f_w0 = pixel_x;
          l_w0 = pixel_x;
        end
        if (win1 === 1'b1) begin
          n_w1++;
          if (f_w1 < 0) f_w1 = pixel_x;
        end
      end
      if (line_done === 1'b1) n_ld++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic start_line(input logic [7:0] v, input logic pe);
    line_start = 1'b1;
    vcount     = v;
    pixel_en   = pe;
    cyc();
    line_start = 1'b0;
    pixel_en   = 1'b0;
  endtask

  task automatic run_pixels(input int n, input int dens);
    int sent;
    sent = 0;
    while (sent < n) begin
      pixel_en = ($urandom_range(99) < dens);
      if (pixel_en) sent++;
      cyc();
    end
    pixel_en = 1'b0;
  endtask

  task automatic full_line(input logic [7:0] v);
    clr_stats();
    start_line(v, 1'b0);
    run_pixels(240, 100);
    repeat (3) cyc();
  endtask

  initial begin
    int k;
    reset = 1'b1; dispcnt = 0; win0h = 0; win1h = 0; win0v = 0; win1v = 0;
    line_start = 0; vcount = 0; pixel_en = 0;
    clr_stats();
    repeat (3) cyc();
    chk("reset_pixel_valid", pixel_valid, 0);
    chk("reset_line_done", line_done, 0);
    chk("reset_win0", win0, 0);
    chk("reset_pixel_x", pixel_x, 0);
    reset = 1'b0;
    cyc();

    // Basic window 0 rectangle.
    win0h = 16'h1050; win0v = 16'h2040; dispcnt = 16'h2000;
    full_line(8'h30);
    chk("t1_win0_count", n_w0, 64);
    chk("t1_win0_first", f_w0, 16);
    chk("t1_win0_last", l_w0, 79);
    chk("t1_win1_count", n_w1, 0);
    chk("t1_pixels", n_pv, 240);
    chk("t1_last_px", last_px, 239);
    chk("t1_line_done", n_ld, 1);

    // Vertical edges: bottom exclusive, above top.
    full_line(8'h40);
    chk("t2_bottom_excl", n_w0, 0);
    full_line(8'h1F);
    chk("t2_above_top", n_w0, 0);

    // Off-screen X2 on window 1.
    win1h = 16'hC8F8; win1v = 16'h00A0; dispcnt = 16'h4000;
    full_line(8'h05);
    chk("t3_win1_count", n_w1, 40);
    chk("t3_win1_first", f_w1, 200);
    chk("t3_win0_off", n_w0, 0);

    // Inverted X edges, then window disabled.
    win0h = 16'h5010; dispcnt = 16'h2000;
    full_line(8'h30);
    chk("t4_inverted_count", n_w0, 160);
    chk("t4_inverted_first", f_w0, 80);
    dispcnt = 16'h0000;
    full_line(8'h30);
    chk("t4_disabled", n_w0, 0);

    // Abort after pixel 100, then a complete line.
    dispcnt = 16'h2000;
    clr_stats();
    start_line(8'h30, 1'b0);
    run_pixels(101, 100);
    start_line(8'h31, 1'b0);
    run_pixels(240, 100);
    repeat (3) cyc();
    chk("t5_abort_line_done", n_ld, 1);
    chk("t5_abort_pixels", n_pv, 341);

    // Vblank line produces nothing.
    clr_stats();
    start_line(8'd200, 1'b0);
    run_pixels(50, 100);
    repeat (3) cyc();
    chk("t5_vblank_pixels", n_pv, 0);
    chk("t5_vblank_done", n_ld, 0);

    // Reset in the middle of a line that has win0 set.
    win0h = 16'h00F0; win0v = 16'h00A0;
    start_line(8'h10, 1'b0);
    run_pixels(30, 100);
    reset = 1'b1; pixel_en = 1'b1;
    cyc();
    chk("t5_rst_win0", win0, 0);
    chk("t5_rst_pixel_x", pixel_x, 0);
    chk("t5_rst_pixel_valid", pixel_valid, 0);
    reset = 1'b0; pixel_en = 1'b0;
    cyc();

    // Mid-line write of WIN0H after pixel 50.
    win0h = 16'h0010; win0v = 16'h00A0; dispcnt = 16'h2000;
    clr_stats();
    start_line(8'h0A, 1'b0);
    run_pixels(51, 100);
    win0h = 16'h00F0;
    run_pixels(189, 100);
    repeat (3) cyc();
`ifdef PE_WIN_SHADOW_EN
    chk("t6_shadow_count", n_w0, 16);
`else
    chk("t6_live_count", n_w0, 205);
`endif

    // Randomized lines: random registers, gaps, mid-line writes, aborts, vblank.
    for (int it = 0; it < 30; it++) begin
      win0h = 16'($urandom); win1h = 16'($urandom);
      win0v = 16'($urandom); win1v = 16'($urandom);
      dispcnt = 16'($urandom);
      if ($urandom_range(3) == 0) win0v = 16'h00A0;
      start_line(8'($urandom_range(0, 200)), 1'($urandom_range(1)));
      k = $urandom_range(1, 239);
      run_pixels(k, $urandom_range(30, 100));
      if ($urandom_range(2) == 0) begin
        win0h = 16'($urandom); win1v = 16'($urandom); dispcnt = 16'($urandom);
      end
      if ($urandom_range(4) != 0) run_pixels(240 - k, $urandom_range(30, 100));
      repeat ($urandom_range(0, 3)) cyc();
    end
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_window_scanner.md
Name: pe_window_scanner

Overview:
- Per-pixel sequencer that generates the `win0` / `win1` window-membership flags consumed by the priority-evaluation window masker.
- Tracks the horizontal pixel position within each visible scanline and evaluates the WIN0H/WIN0V/WIN1H/WIN1V rectangles against the current position.
- Sits between the PPU timing generator (line_start, pixel_en, vcount) and the priority-evaluation stage.

Parameters:
- SCREEN_W, 240, visible pixels per line; also the clamp value for X2.
- SCREEN_H, 160, visible lines; also the clamp value for Y2.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- dispcnt  input  16  DISPCNT; bit13 = WIN0 enable, bit14 = WIN1 enable
- win0h  input  16  [15:8] = X1 left (inclusive), [7:0] = X2 right (exclusive)
- win1h  input  16  same layout as win0h
- win0v  input  16  [15:8] = Y1 top (inclusive), [7:0] = Y2 bottom (exclusive)
- win1v  input  16  same layout as win0v
- line_start  input  1  one-cycle pulse at the start of each scanline
- vcount  input  8  line number; valid while line_start is high
- pixel_en  input  1  advance one pixel
- win0  output  1  current pixel is inside window 0
- win1  output  1  current pixel is inside window 1
- pixel_x  output  8  x coordinate of the pixel whose flags are on win0/win1
- pixel_valid  output  1  win0, win1 and pixel_x are valid this cycle
- line_done  output  1  one-cycle pulse after the last pixel of a line

Behaviour:
- Reset: state = IDLE, x counter = 0, vin0 = vin1 = 0, shadow registers = 0. All outputs are 0.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - line_start with vcount < SCREEN_H → ACTIVE. Same edge: x = 0, capture shadows of win0h/win1h/win0v/win1v/dispcnt, register vin0/vin1 from vcount.
  - line_start with vcount >= SCREEN_H (vblank) → stay IDLE.
- Vertical clamp: Y2eff = SCREEN_H if Y2 > SCREEN_H or Y1 > Y2; otherwise Y2eff = Y2.
- Vertical test: vin = (vcount >= Y1) && (vcount < Y2eff). Y1 == Y2 gives an empty window.
- Horizontal clamp: X2eff = SCREEN_W if X2 > SCREEN_W or X1 > X2; otherwise X2eff = X2.
- Horizontal test: hin = (x >= X1) && (x < X2eff).
- ACTIVE, each pixel_en:
  - next cycle: winN = dispcnt[13+N] & vinN & hinN(x); pixel_x = x; pixel_valid = 1.
  - x increments. Latency is exactly 1 cycle from pixel_en to outputs.
  - Without pixel_en, pixel_valid = 0 next cycle; win0, win1 and pixel_x hold their last values.
- End of line: pixel_en with x == SCREEN_W-1 → DONE. x stays at SCREEN_W-1; no wrap.
- DONE: line_done = 1 for one cycle (same cycle the last pixel_valid drops), then → IDLE. pixel_en in DONE or IDLE is ignored; pixel_valid = 0.
- line_start while ACTIVE or DONE: the line is aborted, handled as in IDLE (re-capture, x = 0). No line_done is emitted for the aborted line.
- Simultaneous line_start and pixel_en: line_start wins; that pixel_en is dropped.
- reset mid-line overrides everything and returns to reset values next cycle.
- Widths: all compares are unsigned 8-bit. SCREEN_W = 240 fits 8 bits; an X2 of 241..255 is clamped.

Optional Feature:
- PE_WIN_SHADOW_EN
  - Defined: window and dispcnt registers are sampled only at line_start; CPU writes mid-line take effect on the next line.
  - Undefined: the horizontal test and dispcnt enables use the live register inputs every pixel. The vertical test still uses vcount latched at line_start, but Y1/Y2 are read live each pixel. The shadow flops are not instantiated.

Decomposition:
- Shared package pe_pkg:
  - localparams PE_SCREEN_W, PE_SCREEN_H
  - FSM enum typedef pe_scan_state_t {IDLE, ACTIVE, DONE}
  - struct pe_win_rect_t {x1, x2, y1, y2}
- One sub-module, pe_win_range_check: combinational clamp + compare, instantiated once per window.

Test Plan:
- WIN0H = 0x1050, WIN0V = 0x2040, dispcnt = 0x2000, line vcount = 0x30, 240 pixel_en → win0 = 1 exactly for pixel_x 16..79; win1 = 0 throughout; line_done pulses once after pixel_x = 239.
- Same WIN0H, vcount = 0x40 and vcount = 0x1F → win0 = 0 for the entire line (Y2 exclusive, above Y1).
- WIN1H = 0xC8F8 (X2 = 248 > 240), WIN1V = 0x00A0, dispcnt = 0x4000 → win1 = 1 for pixel_x 200..239.
- WIN0H = 0x5010 (X1 > X2) → win0 = 1 for pixel_x 80..239; dispcnt = 0x0000 → win0 = 0 everywhere.
- line_start pulsed after pixel 100 → x restarts at 0, no line_done for the aborted line. line_start with vcount = 200 → pixel_valid stays 0. reset asserted mid-line → all outputs 0 the next cycle.
- Write WIN0H = 0x0010 → 0x00F0 at pixel 50 → with PE_WIN_SHADOW_EN, win0 = 0 from pixel 16 (old X2 = 16) for the rest of the line; without it, win0 = 1 from the following pixel to 239.
